calc_operand_seq: RTL
=====================

# calc_operand_seq

Operand sequencer and result latch for the 4-bit calculator datapath. Collects operand A, operand B and the add/subtract selection from a single 4-bit entry bus over successive `load` strobes. It then holds them stable on the add/sub unit's inputs for one execute cycle and registers the unit's sum, carry and overflow. It sits directly upstream of the 4-bit add/subtract unit and drives its A, B and subsel inputs. It also serves as that unit's output register toward display logic.

## Interface
- `W`, 4: operand/result width; fixed to match the add/sub unit.
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `din`  in  W  operand entry bus, sampled only when `load`=1.
- `load`  in  1  one-cycle strobe: capture `din` as next operand.
- `op_sub`  in  1  sampled with B's `load`: 1 = subtract, 0 = add.
- `clear`  in  1  synchronous abort to IDLE; same effect as reset.
- `a_out`  out  W  to add/sub unit A input.
- `b_out`  out  W  to add/sub unit B input.
- `subsel_out`  out  1  to add/sub unit subsel input.
- `x_in`  in  W  add/sub unit sum.
- `cout_in`  in  1  add/sub unit carry-out.
- `ovf_in`  in  1  add/sub unit signed overflow.
- `result`  out  W  registered sum.
- `result_cout`, `result_ovf`  out  1 each  registered flags.
- `result_valid`  out  1  result registers hold a completed operation.
- `busy`  out  1  high in EXEC; `load` ignored.

## Operation
- FSM states: IDLE → A_HELD → EXEC → DONE.
- IDLE: `load` captures `din` into A register and moves to A_HELD.
- A_HELD: `load` captures `din` into B register and `op_sub` into subsel register, then moves to EXEC.
- EXEC: exactly one cycle. The following are ignored:
  - `load`
  - `op_sub`
- End of EXEC: `x_in`, `cout_in` and `ovf_in` are registered into `result`, `result_cout` and `result_ovf`. `result_valid` is set and the FSM moves to DONE.
- DONE: results are held and `result_valid` stays 1.
  - `load` captures `din` as a new A (see Configuration), clears `result_valid` and moves to A_HELD.
- `clear` has priority over `load` in every state. It forces IDLE and zeroes all registers and outputs.
- `a_out`, `b_out` and `subsel_out` are driven directly from the A, B and subsel registers. They are stable for the whole EXEC cycle and hold their last values in other states.
- No arithmetic is done in this block. Results are stored as 4-bit values; wrap-around and flags come solely from the add/sub unit.

## Timing
- Reset (`rst_n`=0 at an edge) and `clear`: state IDLE.
  - All outputs 0: `a_out`, `b_out`, `subsel_out`, `result`, `result_cout`, `result_ovf`, `result_valid`, `busy`.
- Result latency: B is loaded at edge k. EXEC runs between edge k and edge k+1. `result` and `result_valid` are updated at edge k+1.
- The add/sub path must settle within one clock period.
- `busy` is 1 exactly during EXEC, i.e. the single cycle after B's load edge.
- `load` held high for several cycles counts as one capture per cycle. This is legal: in IDLE, two consecutive `load` cycles load A then B.
- `clear` or reset during EXEC: the result is not captured and `result_valid` stays 0.

## Configuration
- `CALC_CHAIN_EN` defined: in DONE, `load` with `op_sub` captures `din` as B. A takes the previous `result` (accumulator chaining) and the FSM goes straight to EXEC.
- Without it: DONE `load` captures `din` as a new A and goes to A_HELD, as described above.

## Structure
- Shared package `calc_pkg`:
  - `CALC_W` = 4.
  - State enum `calc_state_t`: IDLE, A_HELD, EXEC, DONE.
- No sub-module inside; the add/sub unit is instantiated beside this block at the next level up, not within it.

## Test plan
- Add: reset; load 5; load 3 with `op_sub`=0. The cycle after B: `result`=8, `result_cout`=0, `result_ovf`=1, `result_valid`=1, `busy` was 1 for one cycle.
- Subtract: load 3; load 5 with `op_sub`=1. `subsel_out`=1 during EXEC; `result`=4'b1110, `result_cout`=0, `result_ovf`=0.
- Reset values: check every output is 0 after reset. Load 7 and 7, then pulse `clear` during EXEC: state IDLE, `result_valid`=0, `result`=0.
- Ignored input: `load` with `din`=9 during EXEC has no effect; `b_out` stays at the B loaded on the previous edge.
- Chaining: with `CALC_CHAIN_EN` set, 2+3=5, then in DONE load 4 with `op_sub`=1 gives `result`=1 and `result_cout`=1. Without the macro, the same sequence makes 4 the new A and the FSM waits in A_HELD.
- `clear` and `load` asserted together in A_HELD: FSM goes to IDLE and B is not captured.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the 4-bit calculator datapath: operand width and
// operand-sequencer state encoding.
package calc_pkg;

  localparam int CALC_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_HELD = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } calc_state_t;

endpackage : calc_pkg

// File: rtl/calc_operand_seq.sv
// Operand sequencer and result latch feeding the 4-bit add/sub unit.
// Optional macro CALC_CHAIN_EN: a load in DONE chains the previous result as A.
module calc_operand_seq
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CALC_W-1:0] din,
  input  logic              load,
  input  logic              op_sub,
  input  logic              clear,
  output logic [CALC_W-1:0] a_out,
  output logic [CALC_W-1:0] b_out,
  output logic              subsel_out,
  input  logic [CALC_W-1:0] x_in,
  input  logic              cout_in,
  input  logic              ovf_in,
  output logic [CALC_W-1:0] result,
  output logic              result_cout,
  output logic              result_ovf,
  output logic              result_valid,
  output logic              busy
);

  calc_state_t       state_q, state_d;
  logic [CALC_W-1:0] a_q, a_d;
  logic [CALC_W-1:0] b_q, b_d;
  logic              sub_q, sub_d;
  logic [CALC_W-1:0] res_q, res_d;
  logic              res_cout_q, res_cout_d;
  logic              res_ovf_q, res_ovf_d;
  logic              res_valid_q, res_valid_d;

  always_comb begin
    // NOTE: every *_d starts from its *_q so that no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    res_d       = res_q;
    res_cout_d  = res_cout_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;

    if (clear) begin
      state_d     = IDLE;
      a_d         = '0;
      b_d         = '0;
      sub_d       = 1'b0;
      res_d       = '0;
      res_cout_d  = 1'b0;
      res_ovf_d   = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            a_d     = din;
            state_d = A_HELD;
          end
        end
        A_HELD: begin
          if (load) begin
            b_d     = din;
            sub_d   = op_sub;
            state_d = EXEC;
          end
        end
        EXEC: begin
          // Operands have been on the add/sub inputs for a full cycle.
          res_d       = x_in;
          res_cout_d  = cout_in;
          res_ovf_d   = ovf_in;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
        DONE: begin
          if (load) begin
            res_valid_d = 1'b0;
`ifdef CALC_CHAIN_EN
            a_d     = res_q;
            b_d     = din;
            sub_d   = op_sub;
            state_d = EXEC;
`else
            a_d     = din;
            state_d = A_HELD;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is
    // synchronous, sampled on the same edge as every other update.
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      res_q       <= '0;
      res_cout_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      res_q       <= res_d;
      res_cout_q  <= res_cout_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign a_out        = a_q;
  assign b_out        = b_q;
  assign subsel_out   = sub_q;
  assign result       = res_q;
  assign result_cout  = res_cout_q;
  assign result_ovf   = res_ovf_q;
  assign result_valid = res_valid_q;
  assign busy         = (state_q == EXEC);

endmodule : calc_operand_seq
